// File: rtl/adder_rr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_seq_pkg
//  Description : Shared types and constants for the adder round-robin
//                sequencer (FSM states, owner type, widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic owner_t;

    localparam int WIDTH_DEFAULT = 16;
    localparam int CNT_W         = 4;

endpackage
`default_nettype wire

// File: rtl/adder_rr_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : adder_rr_sequencer_if
//  Description : Request/response and adder-side signal bundle for the adder
//                round-robin sequencer. slave = sequencer view, master =
//                requester/adder environment view.
//                Optional macro ADDER_SEQ_SUB_EN adds per-requester req_sub.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adder_rr_sequencer_if
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][WIDTH-1:0] req_a;
    logic [1:0][WIDTH-1:0] req_b;
`ifdef ADDER_SEQ_SUB_EN
    logic [1:0]            req_sub;
`endif
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  add_cin;
    logic [WIDTH-1:0]      add_sum;
    logic                  add_cout;
    logic [1:0]            resp_valid;
    logic [1:0]            resp_ready;
    logic [WIDTH-1:0]      resp_sum;
    logic                  resp_cout;
    logic                  busy;

    modport slave (
        input  req_valid, req_a, req_b,
`ifdef ADDER_SEQ_SUB_EN
        input  req_sub,
`endif
        input  add_sum, add_cout, resp_ready,
        output req_ready, add_a, add_b, add_cin,
        output resp_valid, resp_sum, resp_cout, busy
    );

    modport master (
        output req_valid, req_a, req_b,
`ifdef ADDER_SEQ_SUB_EN
        output req_sub,
`endif
        output add_sum, add_cout, resp_ready,
        input  req_ready, add_a, add_b, add_cin,
        input  resp_valid, resp_sum, resp_cout, busy
    );

endinterface
`default_nettype wire

// File: rtl/adder_rr_sequencer_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way combinational round-robin arbiter. A lone request
//                wins; on a tie the requester that did not win last time wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import adder_seq_pkg::*;
(
    input  wire logic [1:0] i_req,
    input  wire owner_t     i_last_grant,
    output logic [1:0]      o_grant
);

    // One-hot grant; a tie is broken against the previous winner
    always_comb begin
        o_grant    = 2'b00;
        o_grant[0] = i_req[0] & (~i_req[1] | (i_last_grant == 1'b1));
        o_grant[1] = i_req[1] & (~i_req[0] | (i_last_grant == 1'b0));
    end

endmodule
`default_nettype wire

// File: rtl/adder_rr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : adder_rr_sequencer
//  Description : Shares one external combinational adder between two
//                requesters. Round-robin grant, operand capture, ADD_LAT
//                settle cycles on the adder, registered result returned over
//                a valid/ready response channel.
//                Optional macro ADDER_SEQ_SUB_EN enables subtraction via
//                req_sub (add_b = ~b, add_cin = 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_rr_sequencer
    import adder_seq_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int ADD_LAT = 1
)
(
    input  wire logic            clk,
    input  wire logic            rst,
    adder_rr_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_LAT_M1 = CNT_W'(ADD_LAT - 1);

    if (ADD_LAT < 1 || ADD_LAT > 15) begin : g_bad_lat
        $error("adder_rr_sequencer: ADD_LAT must be in 1..15");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    owner_t             r_owner;
    owner_t             r_last_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
`ifdef ADDER_SEQ_SUB_EN
    logic               r_sub;
`endif
    logic [1:0]         r_resp_valid;
    logic [WIDTH-1:0]   r_resp_sum;
    logic               r_resp_cout;

    logic [1:0]         w_grant;
    logic [1:0]         w_req_ready;
    logic               w_accept;
    owner_t             w_acc_idx;
    logic               w_resp_done;

    rr_arbiter2 u_arb (
        .i_req        (bus.req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    assign w_req_ready = (r_state == IDLE) ? w_grant : 2'b00;
    assign w_accept    = |(bus.req_valid & w_req_ready);
    // Grant is one-hot, so bit 1 alone identifies the winner
    assign w_acc_idx   = owner_t'(w_req_ready[1]);
    assign w_resp_done = r_resp_valid[r_owner] & bus.resp_ready[r_owner];

    assign bus.req_ready  = w_req_ready;
    assign bus.add_a      = r_op_a;
`ifdef ADDER_SEQ_SUB_EN
    assign bus.add_b      = r_sub ? ~r_op_b : r_op_b;
    assign bus.add_cin    = r_sub;
`else
    assign bus.add_b      = r_op_b;
    assign bus.add_cin    = 1'b0;
`endif
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_sum   = r_resp_sum;
    assign bus.resp_cout  = r_resp_cout;
    assign bus.busy       = (r_state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: accept -> settle on adder -> wait for owner to take result
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)       w_state_nxt = EXEC;
            EXEC:    if (r_cnt == '0)    w_state_nxt = RESP;
            RESP:    if (w_resp_done)    w_state_nxt = IDLE;
            default:                     w_state_nxt = IDLE;
        endcase
    end

    // Operand capture, settle counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a       <= '0;
            r_op_b       <= '0;
`ifdef ADDER_SEQ_SUB_EN
            r_sub        <= 1'b0;
`endif
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_resp_valid <= 2'b00;
            r_resp_sum   <= '0;
            r_resp_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op_a       <= bus.req_a[w_acc_idx];
                        r_op_b       <= bus.req_b[w_acc_idx];
`ifdef ADDER_SEQ_SUB_EN
                        r_sub        <= bus.req_sub[w_acc_idx];
`endif
                        r_owner      <= w_acc_idx;
                        r_last_grant <= w_acc_idx;
                        r_cnt        <= c_LAT_M1;
                    end
                end
                EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_resp_sum            <= bus.add_sum;
                        r_resp_cout           <= bus.add_cout;
                        r_resp_valid[r_owner] <= 1'b1;
                    end
                end
                RESP: begin
                    if (w_resp_done) begin
                        r_resp_valid <= 2'b00;
                    end
                end
                default: begin
                    r_resp_valid <= 2'b00;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_rr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_adder_rr_sequencer
//  Description : Self-checking bench for adder_rr_sequencer. Two instances
//                (ADD_LAT=1 and ADD_LAT=3) share one behavioural model per
//                instance; directed scenarios plus a randomized phase.
//                Subtraction scenario compiled only with ADDER_SEQ_SUB_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_rr_sequencer;
    import adder_seq_pkg::*;

    localparam int W = 16;
`ifdef ADDER_SEQ_SUB_EN
    localparam bit c_SUB_EN = 1'b1;
`else
    localparam bit c_SUB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus, indexed by instance (0: ADD_LAT=1, 1: ADD_LAT=3)
    logic [1:0]                 s_rst;
    logic [1:0][1:0]            s_req_valid;
    logic [1:0][1:0][W-1:0]     s_req_a;
    logic [1:0][1:0][W-1:0]     s_req_b;
    logic [1:0][1:0]            s_req_sub;
    logic [1:0][1:0]            s_resp_ready;

    // Observed outputs
    logic [1:0][1:0]            o_req_ready;
    logic [1:0][1:0]            o_resp_valid;
    logic [1:0][W-1:0]          o_add_a;
    logic [1:0][W-1:0]          o_add_b;
    logic [1:0][W-1:0]          o_resp_sum;
    logic [1:0]                 o_add_cin;
    logic [1:0]                 o_resp_cout;
    logic [1:0]                 o_busy;
    logic [1:0][W:0]            s_adder;

    adder_rr_sequencer_if #(.WIDTH(W)) if0 ();
    adder_rr_sequencer_if #(.WIDTH(W)) if1 ();

    adder_rr_sequencer #(.WIDTH(W), .ADD_LAT(1)) u_dut_lat1 (
        .clk (clk),
        .rst (s_rst[0]),
        .bus (if0.slave)
    );

    adder_rr_sequencer #(.WIDTH(W), .ADD_LAT(3)) u_dut_lat3 (
        .clk (clk),
        .rst (s_rst[1]),
        .bus (if1.slave)
    );

    // External combinational adder for each instance
    assign s_adder[0] = {1'b0, o_add_a[0]} + {1'b0, o_add_b[0]} + {{W{1'b0}}, o_add_cin[0]};
    assign s_adder[1] = {1'b0, o_add_a[1]} + {1'b0, o_add_b[1]} + {{W{1'b0}}, o_add_cin[1]};

    assign if0.req_valid  = s_req_valid[0];
    assign if0.req_a      = s_req_a[0];
    assign if0.req_b      = s_req_b[0];
    assign if0.resp_ready = s_resp_ready[0];
    assign if0.add_sum    = s_adder[0][W-1:0];
    assign if0.add_cout   = s_adder[0][W];
    assign if1.req_valid  = s_req_valid[1];
    assign if1.req_a      = s_req_a[1];
    assign if1.req_b      = s_req_b[1];
    assign if1.resp_ready = s_resp_ready[1];
    assign if1.add_sum    = s_adder[1][W-1:0];
    assign if1.add_cout   = s_adder[1][W];
`ifdef ADDER_SEQ_SUB_EN
    assign if0.req_sub    = s_req_sub[0];
    assign if1.req_sub    = s_req_sub[1];
`endif

    assign o_req_ready[0]  = if0.req_ready;
    assign o_resp_valid[0] = if0.resp_valid;
    assign o_add_a[0]      = if0.add_a;
    assign o_add_b[0]      = if0.add_b;
    assign o_add_cin[0]    = if0.add_cin;
    assign o_resp_sum[0]   = if0.resp_sum;
    assign o_resp_cout[0]  = if0.resp_cout;
    assign o_busy[0]       = if0.busy;
    assign o_req_ready[1]  = if1.req_ready;
    assign o_resp_valid[1] = if1.resp_valid;
    assign o_add_a[1]      = if1.add_a;
    assign o_add_b[1]      = if1.add_b;
    assign o_add_cin[1]    = if1.add_cin;
    assign o_resp_sum[1]   = if1.resp_sum;
    assign o_resp_cout[1]  = if1.resp_cout;
    assign o_busy[1]       = if1.busy;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, g, $time, act, exp);
        end
    endtask

    // Who should win: a lone requester, or on a tie the one that did not win last
    function automatic logic [1:0] rr_pick(input logic [1:0] v, input bit last);
        case (v)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return last ? 2'b01 : 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Behavioural model: one operation in flight, result visible LAT+1 cycles
    // after the accept cycle, held until the owner takes it.
    for (genvar g = 0; g < 2; g++) begin : g_model
        localparam int LAT = (g == 0) ? 1 : 3;
        bit           m_on    = 1'b0;
        bit           m_busy  = 1'b0;
        bit           m_owner = 1'b0;
        bit           m_last  = 1'b1;
        bit           m_sub   = 1'b0;
        logic [W-1:0] m_a     = '0;
        logic [W-1:0] m_b     = '0;
        logic [W-1:0] m_rsum  = '0;
        logic         m_rcout = 1'b0;
        int           m_cyc   = 0;
        int           m_acc   = 0;

        always @(negedge clk) begin
            logic [1:0]   gnt;
            logic [1:0]   e_rv;
            logic [W:0]   full;
            gnt = rr_pick(s_req_valid[g], m_last);
            if (m_on) begin
                e_rv = (m_busy && m_cyc >= m_acc + LAT + 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
                chk("req_ready",  g, 32'(o_req_ready[g]),  32'(m_busy ? 2'b00 : gnt));
                chk("resp_valid", g, 32'(o_resp_valid[g]), 32'(e_rv));
                chk("busy",       g, 32'(o_busy[g]),       32'(m_busy));
                chk("add_a",      g, 32'(o_add_a[g]),      32'(m_a));
                chk("add_b",      g, 32'(o_add_b[g]),      32'(m_sub ? ~m_b : m_b));
                chk("add_cin",    g, 32'(o_add_cin[g]),    32'(m_sub));
                chk("resp_sum",   g, 32'(o_resp_sum[g]),   32'(m_rsum));
                chk("resp_cout",  g, 32'(o_resp_cout[g]),  32'(m_rcout));
            end
            if (s_rst[g]) begin
                m_on = 1'b1; m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_sub = 1'b0;
                m_a = '0; m_b = '0; m_rsum = '0; m_rcout = 1'b0;
            end else if (m_on) begin
                if (m_busy) begin
                    if (m_cyc == m_acc + LAT) begin
                        if (m_sub) begin
                            m_rsum  = m_a - m_b;
                            m_rcout = (m_a >= m_b);
                        end else begin
                            full    = {1'b0, m_a} + {1'b0, m_b};
                            m_rsum  = full[W-1:0];
                            m_rcout = full[W];
                        end
                    end
                    if (m_cyc >= m_acc + LAT + 1 && s_resp_ready[g][m_owner])
                        m_busy = 1'b0;
                end else if (gnt != 2'b00) begin
                    m_owner = gnt[1];
                    m_last  = gnt[1];
                    m_a     = s_req_a[g][gnt[1]];
                    m_b     = s_req_b[g][gnt[1]];
                    m_sub   = c_SUB_EN && s_req_sub[g][gnt[1]];
                    m_acc   = m_cyc;
                    m_busy  = 1'b1;
                end
            end
            m_cyc++;
        end
    end

    // One request on instance k from requester r; returns result and the
    // number of cycles from accept cycle to resp_valid
    task automatic op(input int k, input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sub, output logic [W-1:0] sum, output logic cout, output int lat);
        int n;
        @(posedge clk); #1;
        s_req_a[k][r] = a; s_req_b[k][r] = b; s_req_sub[k][r] = sub;
        s_req_valid[k][r] = 1'b1; s_resp_ready[k] = 2'b11;
        n = 0;
        @(negedge clk);
        while (!o_req_ready[k][r] && n < 40) begin @(negedge clk); n++; end
        if (!o_req_ready[k][r]) chk("accept_timeout", k, 32'd0, 32'd1);
        @(posedge clk); #1;
        s_req_valid[k][r] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!o_resp_valid[k][r] && lat < 40) begin @(negedge clk); lat++; end
        if (!o_resp_valid[k][r]) chk("resp_timeout", k, 32'd0, 32'd1);
        sum  = o_resp_sum[k];
        cout = o_resp_cout[k];
    endtask

    task automatic drain(input int k);
        int n;
        @(posedge clk); #1;
        s_req_valid[k] = 2'b00; s_resp_ready[k] = 2'b11;
        n = 0;
        @(negedge clk);
        while (o_busy[k] && n < 60) begin @(negedge clk); n++; end
        if (o_busy[k]) chk("drain_timeout", k, 32'd0, 32'd1);
    endtask

    task automatic rst_dut(input int k);
        @(posedge clk); #1; s_rst[k] = 1'b1;
        @(posedge clk); #1; s_rst[k] = 1'b0;
    endtask

    initial begin
        logic [W-1:0] sum;
        logic         cout;
        int           lat;
        int           n, ng, nr;
        int           gr [4];
        logic [1:0]   rb [4];
        logic [W-1:0] rs [4];
        logic [1:0]   w;

        s_rst = 2'b11; s_req_valid = '0; s_req_a = '0; s_req_b = '0;
        s_req_sub = '0; s_resp_ready = '0;
        repeat (3) @(posedge clk);
        #1; s_rst = 2'b00;

        // Reset state on both instances
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy",  k, 32'(o_busy[k]),       32'd0);
            chk("rst_rv",    k, 32'(o_resp_valid[k]), 32'd0);
            chk("rst_sum",   k, 32'(o_resp_sum[k]),   32'd0);
            chk("rst_add_a", k, 32'(o_add_a[k]),      32'd0);
            chk("rst_cin",   k, 32'(o_add_cin[k]),    32'd0);
        end

        // Single request, ADD_LAT=1
        op(0, 0, 16'h1234, 16'h0F0F, 1'b0, sum, cout, lat);
        chk("single_sum",  0, 32'(sum),  32'h2143);
        chk("single_cout", 0, 32'(cout), 32'd0);
        chk("single_lat",  0, 32'(lat),  32'd2);
        chk("model_sum",   0, 32'(g_model[0].m_rsum), 32'h2143);

        // Overflow
        op(0, 1, 16'hFFFF, 16'h0001, 1'b0, sum, cout, lat);
        chk("ovf_sum",  0, 32'(sum),  32'h0000);
        chk("ovf_cout", 0, 32'(cout), 32'd1);

        // ADD_LAT=3 latency
        op(1, 0, 16'h4000, 16'h0123, 1'b0, sum, cout, lat);
        chk("lat3_lat", 1, 32'(lat), 32'd4);
        chk("lat3_sum", 1, 32'(sum), 32'h4123);
        chk("model_sum3", 1, 32'(g_model[1].m_rsum), 32'h4123);
        drain(0); drain(1);

        // Fairness: both requesters valid continuously after a reset
        rst_dut(0);
        @(posedge clk); #1;
        s_req_a[0] = {16'd100, 16'd7}; s_req_b[0] = {16'd200, 16'd8};
        s_req_valid[0] = 2'b11; s_resp_ready[0] = 2'b11;
        ng = 0; nr = 0; n = 0;
        while (nr < 4 && n < 60) begin
            @(negedge clk); n++;
            w = o_req_ready[0] & s_req_valid[0];
            if (w != 2'b00 && ng < 4) begin gr[ng] = w[1] ? 1 : 0; ng++; end
            if (o_resp_valid[0] != 2'b00 && nr < 4) begin
                rb[nr] = o_resp_valid[0]; rs[nr] = o_resp_sum[0]; nr++;
            end
        end
        @(posedge clk); #1; s_req_valid[0] = 2'b00;
        chk("fair_count", 0, 32'(nr), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("fair_grant", 0, 32'(gr[i]), (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("fair_rbit",  0, 32'(rb[i]), (i % 2 == 1) ? 32'd2 : 32'd1);
            chk("fair_sum",   0, 32'(rs[i]), (i % 2 == 1) ? 32'd300 : 32'd15);
        end
        drain(0);

        // Backpressure on requester 1 while requester 0 waits
        @(posedge clk); #1;
        s_req_a[0][1] = 16'h0102; s_req_b[0][1] = 16'h0304;
        s_req_valid[0] = 2'b10; s_resp_ready[0] = 2'b01;
        n = 0;
        @(negedge clk);
        while (!o_req_ready[0][1] && n < 40) begin @(negedge clk); n++; end
        if (!o_req_ready[0][1]) chk("bp_accept_timeout", 0, 32'd0, 32'd1);
        @(posedge clk); #1;
        s_req_valid[0] = 2'b01; s_req_a[0][0] = 16'h1111; s_req_b[0][0] = 16'h2222;
        n = 0;
        @(negedge clk);
        while (!o_resp_valid[0][1] && n < 40) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_sum",   0, 32'(o_resp_sum[0]),   32'h0406);
            chk("bp_rv",    0, 32'(o_resp_valid[0]), 32'd2);
            chk("bp_busy",  0, 32'(o_busy[0]),       32'd1);
            chk("bp_ready", 0, 32'(o_req_ready[0]),  32'd0);
        end
        @(posedge clk); #1; s_resp_ready[0] = 2'b11;
        @(negedge clk);
        chk("bp_hs_rv",   0, 32'(o_resp_valid[0]), 32'd2);
        @(negedge clk);
        chk("bp_idle",    0, 32'(o_busy[0]),       32'd0);
        chk("bp_next",    0, 32'(o_req_ready[0]),  32'd1);
        drain(0);

        // Reset mid-EXEC on the ADD_LAT=3 instance
        @(posedge clk); #1;
        s_req_a[1][0] = 16'h00AA; s_req_b[1][0] = 16'h0055;
        s_req_valid[1] = 2'b01; s_resp_ready[1] = 2'b11;
        n = 0;
        @(negedge clk);
        while (!o_req_ready[1][0] && n < 40) begin @(negedge clk); n++; end
        @(posedge clk); #1; s_req_valid[1] = 2'b00;
        @(posedge clk); #1; s_rst[1] = 1'b1;
        @(posedge clk); #1; s_rst[1] = 1'b0; s_req_valid[1] = 2'b11;
        @(negedge clk);
        chk("mrst_busy",  1, 32'(o_busy[1]),       32'd0);
        chk("mrst_rv",    1, 32'(o_resp_valid[1]), 32'd0);
        chk("mrst_add_a", 1, 32'(o_add_a[1]),      32'd0);
        chk("mrst_add_b", 1, 32'(o_add_b[1]),      32'd0);
        chk("mrst_sum",   1, 32'(o_resp_sum[1]),   32'd0);
        chk("mrst_grant", 1, 32'(o_req_ready[1]),  32'd1);
        drain(1);

`ifdef ADDER_SEQ_SUB_EN
        op(0, 0, 16'd5, 16'd7, 1'b1, sum, cout, lat);
        chk("sub_sum",  0, 32'(sum),  32'hFFFE);
        chk("sub_cout", 0, 32'(cout), 32'd0);
        drain(0);
`endif

        // Randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                s_req_valid[k]  = 2'($urandom);
                s_req_a[k]      = {16'($urandom), 16'($urandom)};
                s_req_b[k]      = {16'($urandom), 16'($urandom)};
                s_req_sub[k]    = 2'($urandom);
                s_resp_ready[k] = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
                s_rst[k]        = ($urandom_range(0, 199) == 0);
            end
        end
        @(posedge clk); #1; s_rst = 2'b00;
        drain(0); drain(1);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_rr_sequencer.md
Name: adder_rr_sequencer

Overview:
- Shares one external 16-bit combinational adder (the lab4 CLA/ripple/select adders) between two requesters.
- Arbitrates round-robin, captures operands, holds them on the adder for ADD_LAT cycles, then registers sum and carry.
- Returns the result to the winning requester over a valid/ready response channel.
- Sits between requester logic (switch loader, future multiplier sequencer) and the adder instance in the toplevel.

Parameters:
WIDTH, 16, operand and sum width.
ADD_LAT, 1, settle cycles operands are held on the adder before capture; legal 1..15; ADD_LAT=0 fails elaboration via $error.

Ports:
Clk  in  1  system clock; all state on rising edge.
Reset  in  1  synchronous, active-high reset.
req_valid  in  2  per-requester request valid.
req_ready  out  2  per-requester request accept.
req_a  in  2xWIDTH  operand A per requester.
req_b  in  2xWIDTH  operand B per requester.
add_a  out  WIDTH  to adder A input.
add_b  out  WIDTH  to adder B input.
add_cin  out  1  to adder carry-in.
add_sum  in  WIDTH  adder sum.
add_cout  in  1  adder carry-out.
resp_valid  out  2  per-requester result valid.
resp_ready  in  2  per-requester result accept.
resp_sum  out  WIDTH  registered result; shared by both requesters.
resp_cout  out  1  registered carry-out.
busy  out  1  high when not in IDLE.

Behaviour:
- Reset values:
  - state=IDLE.
  - req_ready=0, resp_valid=0, resp_sum=0, resp_cout=0.
  - add_a=0, add_b=0, add_cin=0, busy=0.
  - last_grant=1, so requester 0 wins the first tie.
- FSM states are IDLE, EXEC, RESP.
- IDLE: combinational grant.
  - Only one req_valid set: that requester is granted.
  - Both set: the requester not equal to last_grant is granted.
  - req_ready[i] = (state==IDLE) & grant[i]; at most one bit is ever set.
  - On req_valid[i]&req_ready[i]: capture req_a[i]/req_b[i] into operand registers, owner=i, last_grant=i, cnt=ADD_LAT-1, go to EXEC.
  - A requester dropping valid without a handshake causes no state change.
- EXEC: add_a/add_b are driven from the operand registers and are stable for all ADD_LAT cycles.
  - cnt!=0: decrement.
  - cnt==0: resp_sum<=add_sum, resp_cout<=add_cout, resp_valid[owner]<=1, go to RESP.
- RESP: resp_sum/resp_cout are held.
  - On resp_valid[owner]&resp_ready[owner]: clear resp_valid and go to IDLE.
  - resp_ready of the non-owner is ignored.
- Timing:
  - Accept edge at cycle T; resp_valid is high from cycle T+ADD_LAT+1.
  - With immediate resp_ready, the next accept is no earlier than T+ADD_LAT+2.
  - No request is accepted while busy.
- Arithmetic: sum is modulo 2^WIDTH; carry is reported only on resp_cout. add_cin=0 unless the optional feature is enabled.
- add_a/add_b keep the last operands after an operation; they are not zeroed.
- Reset asserted in any state discards the in-flight operation; all outputs take reset values on the next edge.
- Simultaneous resp handshake and a new req_valid: the new request is not accepted until the cycle after returning to IDLE.

Optional Feature:
- Macro: ADDER_SEQ_SUB_EN.
- Defined:
  - Adds input req_sub (2 bits), captured with the operands.
  - A captured sub=1 drives add_b=~b and add_cin=1, giving resp_sum=a-b mod 2^WIDTH.
  - resp_cout=1 means no borrow.
- Undefined: req_sub is absent; add_cin is constant 0.

Decomposition:
- Package adder_seq_pkg:
  - state_t enum {IDLE, EXEC, RESP}.
  - owner_t (1 bit).
  - WIDTH_DEFAULT=16.
  - CNT_W=4.
- Sub-module rr_arbiter2:
  - Inputs: req[1:0], last_grant.
  - Output: one-hot grant[1:0].
  - Purely combinational.

Test Plan:
- Single request, ADD_LAT=1: req0 a=0x1234, b=0x0F0F accepted at T -> resp_valid[0] at T+2, resp_sum=0x2143, resp_cout=0.
- Overflow: a=0xFFFF, b=0x0001 -> resp_sum=0x0000, resp_cout=1.
- Fairness, both requesters valid continuously (req0 7+8, req1 100+200):
  - Grants alternate 0,1,0,1.
  - Results 15 and 300 go to the correct resp_valid bit.
- Backpressure: resp_ready[1]=0 for 5 cycles:
  - resp_sum stable and busy=1.
  - req_ready=0 throughout.
  - Handshake on cycle 6 returns to IDLE.
- ADD_LAT=3: add_a/add_b held constant for 3 cycles; resp_valid at T+4.
- Reset mid-EXEC -> next cycle all outputs zero, busy=0; the following req0 is granted first.
- With ADDER_SEQ_SUB_EN: a=5, b=7, sub=1 -> resp_sum=0xFFFE, resp_cout=0.
